// File: rtl/bcd_tick_counter_pkg.sv
// Shared constants for the BCD tick counter: default terminal count, FSM
// state encodings and digit width.
package bcd_tick_counter_pkg;

  localparam int DEFAULT_MAX_COUNT = 59;
  localparam int BCD_W             = 4;

  localparam logic [0:0] STOPPED = 1'b0;
  localparam logic [0:0] RUNNING = 1'b1;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
  } bcd_count_t;

endpackage

// File: rtl/bcd_tick_counter_sync_edge_det.sv
// Two-flop synchronizer followed by a rising-edge detector that emits a
// one-CLK pulse per low-to-high transition of d_in.
module sync_edge_det (
  input  logic CLK,
  input  logic rst_n,
  input  logic d_in,
  output logic rise_pulse
);

  logic       sync_a;
  logic       sync_b;
  logic       prev;
  logic [1:0] fill;

  // fill counts edges since reset so that prev only qualifies an edge once it
  // holds a genuine sample; a level already high at reset release is ignored.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      prev   <= 1'b0;
      fill   <= 2'd0;
    end else begin
      sync_a <= d_in;
      sync_b <= sync_a;
      prev   <= sync_b;
      if (fill != 2'd3) begin
        fill <= fill + 2'd1;
      end
    end
  end

  assign rise_pulse = sync_b & ~prev & (fill == 2'd3);

endmodule

// File: rtl/bcd_tick_counter.sv
// Two-digit BCD up/down counter advanced by synchronized tick_in edges,
// gated by a STOPPED/RUNNING controller, with a one-cycle wrap pulse.
module bcd_tick_counter
  import bcd_tick_counter_pkg::*;
#(
  parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             tick_in,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  input  logic             up_dn,
  output logic [BCD_W-1:0] bcd_tens,
  output logic [BCD_W-1:0] bcd_ones,
  output logic             wrap,
  output logic             running
);

  localparam logic [BCD_W-1:0] MAX_TENS = BCD_W'(MAX_COUNT / 10);
  localparam logic [BCD_W-1:0] MAX_ONES = BCD_W'(MAX_COUNT % 10);

  logic             step;
  logic [0:0]       state;
  logic [0:0]       state_nxt;
  logic [BCD_W-1:0] tens_nxt;
  logic [BCD_W-1:0] ones_nxt;
  logic             wrap_nxt;

  sync_edge_det u_sync_edge_det (
    .CLK        (CLK),
    .rst_n      (rst_n),
    .d_in       (tick_in),
    .rise_pulse (step)
  );

  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = STOPPED;
    end else if (start) begin
      state_nxt = RUNNING;
    end
  end

  // Digit-wise BCD increment/decrement with terminal-count wrap in both directions.
  always_comb begin
    tens_nxt = bcd_tens;
    ones_nxt = bcd_ones;
    wrap_nxt = 1'b0;
    if (up_dn) begin
      if (bcd_tens == MAX_TENS && bcd_ones == MAX_ONES) begin
        tens_nxt = '0;
        ones_nxt = '0;
        wrap_nxt = 1'b1;
      end else if (bcd_ones == 4'd9) begin
        ones_nxt = '0;
        tens_nxt = bcd_tens + 4'd1;
      end else begin
        ones_nxt = bcd_ones + 4'd1;
      end
    end else begin
      if (bcd_tens == 4'd0 && bcd_ones == 4'd0) begin
        tens_nxt = MAX_TENS;
        ones_nxt = MAX_ONES;
        wrap_nxt = 1'b1;
      end else if (bcd_ones == 4'd0) begin
        ones_nxt = 4'd9;
        tens_nxt = bcd_tens - 4'd1;
      end else begin
        ones_nxt = bcd_ones - 4'd1;
      end
    end
  end

  // clr outranks a step; steps arriving while STOPPED are dropped.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state    <= STOPPED;
      bcd_tens <= '0;
      bcd_ones <= '0;
      wrap     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        bcd_tens <= '0;
        bcd_ones <= '0;
        wrap     <= 1'b0;
      end else if (step && state == RUNNING) begin
        bcd_tens <= tens_nxt;
        bcd_ones <= ones_nxt;
        wrap     <= wrap_nxt;
      end else begin
        wrap <= 1'b0;
      end
    end
  end

  assign running = (state == RUNNING);

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Scoreboard bench for bcd_tick_counter: directed scenarios plus random
// traffic, checked against an integer-valued reference model.
module tb_bcd_tick_counter;

  localparam int MAXC = 59;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       clr = 1'b0;
  logic       up_dn = 1'b1;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       wrap;
  logic       running;

  typedef struct {
    int tens;
    int ones;
    bit wrap;
    bit run;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  bit   hist[0:15999];
  int   cyc = 0;
  int   lastRst = 0;
  int   mVal = 0;
  bit   mRun = 0;
  bit   gUp = 1'b1;
  bit   tRand = 1'b0;

  always #5 CLK = ~CLK;

  bcd_tick_counter #(.MAX_COUNT(MAXC)) dut (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .tick_in  (tick_in),
    .start    (start),
    .stop     (stop),
    .clr      (clr),
    .up_dn    (up_dn),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .wrap     (wrap),
    .running  (running)
  );

  // Drives one cycle of inputs and pushes the state the model predicts after
  // the following rising edge. A step lands two edges after tick_in is first
  // seen high, provided both samples involved were taken after reset.
  task automatic applyStimulus(input bit r, input bit s, input bit p,
                               input bit c, input bit u, input bit t);
    exp_t e;
    bit   stepNow;
    @(negedge CLK);
    rst_n   = r;
    start   = s;
    stop    = p;
    clr     = c;
    up_dn   = u;
    tick_in = t;
    cyc++;
    hist[cyc] = t;
    e.wrap = 1'b0;
    if (!r) begin
      mVal    = 0;
      mRun    = 1'b0;
      lastRst = cyc;
    end else begin
      stepNow = 1'b0;
      if (cyc - 3 > lastRst) begin
        stepNow = hist[cyc-2] && !hist[cyc-3];
      end
      if (c) begin
        mVal = 0;
      end else if (stepNow && mRun) begin
        if (u) begin
          if (mVal == MAXC) begin
            mVal   = 0;
            e.wrap = 1'b1;
          end else begin
            mVal++;
          end
        end else begin
          if (mVal == 0) begin
            mVal   = MAXC;
            e.wrap = 1'b1;
          end else begin
            mVal--;
          end
        end
      end
      if (p) begin
        mRun = 1'b0;
      end else if (s) begin
        mRun = 1'b1;
      end
    end
    e.tens = mVal / 10;
    e.ones = mVal % 10;
    e.run  = mRun;
    expQ.push_back(e);
  endtask

  task automatic cycleIdle(input bit t);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, gUp, t);
  endtask

  task automatic tickPulses(input int n);
    for (int i = 0; i < n; i++) begin
      cycleIdle(1'b1);
      cycleIdle(1'b1);
      cycleIdle(1'b0);
      cycleIdle(1'b0);
    end
  endtask

  // Directed spot check against constants, taken just after the edge that the
  // most recent stimulus targeted.
  task automatic checkOutput(input string name, input int tens, input int ones,
                             input bit run);
    @(posedge CLK);
    #2;
    checks++;
    if (bcd_tens !== 4'(tens) || bcd_ones !== 4'(ones) || running !== run) begin
      errors++;
      $display("[TB] FAIL %s: got %0d/%0d running=%0b, expected %0d/%0d running=%0b",
               name, bcd_tens, bcd_ones, running, tens, ones, run);
    end
  endtask

  // Monitor: one expected entry per stimulated cycle, compared after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checks++;
        if (bcd_tens !== 4'(e.tens) || bcd_ones !== 4'(e.ones) ||
            wrap !== e.wrap || running !== e.run) begin
          errors++;
          $display("[TB] FAIL scoreboard t=%0t: got %0d/%0d wrap=%0b running=%0b, expected %0d/%0d wrap=%0b running=%0b",
                   $time, bcd_tens, bcd_ones, wrap, running,
                   e.tens, e.ones, e.wrap, e.run);
        end
      end
    end
  end

  initial begin
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("reset", 0, 0, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) cycleIdle(1'b0);
    tickPulses(3);
    repeat (4) cycleIdle(1'b0);
    checkOutput("three_up_steps", 0, 3, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tickPulses(59);
    checkOutput("preload_59", 5, 9, 1'b1);
    tickPulses(1);
    checkOutput("up_wrap", 0, 0, 1'b1);

    gUp = 1'b0;
    tickPulses(1);
    checkOutput("down_wrap", 5, 9, 1'b1);
    tickPulses(1);
    checkOutput("down_after_wrap", 5, 8, 1'b1);
    gUp = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tickPulses(9);
    checkOutput("count_09", 0, 9, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tickPulses(4);
    checkOutput("stop_wins", 0, 9, 1'b0);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tickPulses(42);
    checkOutput("count_42", 4, 2, 1'b1);
    cycleIdle(1'b1);
    cycleIdle(1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("clr_beats_step", 0, 0, 1'b1);
    cycleIdle(1'b0);

    repeat (1000) cycleIdle(1'b1);
    repeat (3) cycleIdle(1'b0);
    checkOutput("long_high_one_step", 0, 1, 1'b1);

    tickPulses(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("mid_count_reset", 0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (10) cycleIdle(1'b1);
    checkOutput("high_at_release", 0, 0, 1'b1);
    repeat (2) cycleIdle(1'b0);
    tickPulses(1);
    checkOutput("first_edge_after_release", 0, 1, 1'b1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) gUp = ~gUp;
      if ($urandom_range(0, 2) == 0) tRand = ~tRand;
      applyStimulus($urandom_range(0, 199) != 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0,
                    gUp, tRand);
    end

    @(posedge CLK);
    #3;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
